bsg_8b10b_symbol_decoder: RTL and testbench
===========================================

# bsg_8b10b_symbol_decoder

Registered 8b/10b decoder for one parallel 10-bit code-group per valid cycle. It tracks running disparity (RD), flags code and disparity violations, and reports link lock after a run of error-free symbols. It sits between a deserializer/aligner and the link-layer framer.

## Interface

Parameters:
- `lock_count_p`, default 15: number of consecutive error-free valid symbols, minus one, required to assert lock. Must be ≥ 0.

Ports (one clock; reset is synchronous and active-low):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_n_i`  in  1  synchronous active-low reset.
- `v_i`  in  1  `data_i` holds a code-group this cycle.
- `data_i`  in  10  code-group, bit 0 = a (first on wire): [5:0]=a,b,c,d,e,i; [9:6]=f,g,h,j.
- `rd_load_v_i`  in  1  force the RD register.
- `rd_load_i`  in  1  RD value to force: 0 = RD−, 1 = RD+.
- `v_o`  out  1  registered valid: symbol decoded with no error.
- `data_o`  out  8  decoded byte, HGF_EDCBA.
- `k_o`  out  1  symbol is a control (K) code.
- `data_err_o`  out  1  invalid code-group.
- `rd_err_o`  out  1  disparity violation.
- `rd_o`  out  1  current RD register value.
- `lock_o`  out  1  link locked.

## Operation

- The combinational decode uses IEEE 802.3 Clause 36 5b/6b and 3b/4b tables.
  - Input is `data_i` plus the current RD register `rd_r`.
  - It produces `data`, `k`, `rd_next`, `data_err` and `rd_err`.
- `k` is 1 only for K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7.
- The D.x.A7 alternate (fghj 0111/1000) is valid only where the standard allows it.
- `data_err` is 1 for any 10-bit pattern absent from the valid code-group table for both disparities.
  - This includes 6b disparity ±4/±6 and 4b patterns 0000 and 1111.
- `rd_err`, 6b sub-block:
  - error if disparity is +2 with RD+, or −2 with RD−;
  - error if the pattern is 111000 with RD+, or 000111 with RD−.
  - Mid-RD is + after a +2 sub-block, − after a −2 sub-block, otherwise unchanged.
- `rd_err`, 4b sub-block, against mid-RD:
  - same disparity rule as the 6b sub-block;
  - error if the pattern is 1100 with mid RD+, or 0011 with mid RD−.
- `rd_next` is the RD after the 4b sub-block.
- Registered outputs when `v_i`=1:
  - `v_o` = ~(data_err | rd_err);
  - `data_o`, `k_o`, `data_err_o` and `rd_err_o` load the decode results.
- Registered outputs when `v_i`=0:
  - `v_o`, `data_err_o` and `rd_err_o` are 0;
  - `data_o` and `k_o` hold their previous values.
- RD register update, in priority order:
  - `rd_load_v_i` → `rd_load_i`;
  - else `v_i` and no error → `rd_next`;
  - else hold.
  - A symbol arriving in the same cycle as a load is decoded with the old `rd_r`.
- Lock counter:
  - increments on each error-free valid symbol;
  - clears to 0 on any errored valid symbol.
  - When the count equals `lock_count_p` and increments, `lock_o` sets and the counter wraps to 0.
  - `lock_o` is sticky until an errored valid symbol or reset clears it.

## Timing

- Decode latency is 1 cycle: a symbol presented at edge N appears on the outputs after edge N.
- Reset values: `v_o`=0, `data_o`=0, `k_o`=0, `data_err_o`=0, `rd_err_o`=0, `rd_o`=0 (RD−), `lock_o`=0, counter=0.
- Reset overrides every input, including `rd_load_v_i`.
- Reset mid-stream discards the in-flight symbol: outputs are 0 on the next cycle.
- Error and lock clear are simultaneous: `lock_o` falls in the same cycle that `v_o`=0 with an error flag.
- `rd_o` reflects `rd_r` with no added delay.

## Structure

- Shared package `bsg_8b10b_pkg`:
  - K-code byte constants: K28_0=0x1C, K28_1=0x3C, K28_5=0xBC, K23_7=0xF7, K27_7=0xFB, K29_7=0xFD, K30_7=0xFE;
  - RD encoding localparams (RD_NEG=0, RD_POS=1).
- Sub-modules:
  - `bsg_8b10b_decode_comb`: purely combinational table decode.
  - `bsg_counter_overflow_en`: lock counter.
  - `bsg_dff`: RD register.
- The top level adds the output registers, RD mux and lock flop.

## Test plan

- Reset, then `v_i`=1, `data_i`=0x17C (K28.5 RD−) → next cycle `v_o`=1, `data_o`=0xBC, `k_o`=1, `rd_o`=1.
- From RD+, `data_i`=0x283 (K28.5 RD+) → `data_o`=0xBC, `k_o`=1, `rd_o`=0.
- From RD−, `data_i`=0x0B9 (D0.0) → `data_o`=0x00, `k_o`=0, `rd_o` stays 0.
- `data_i`=0x17C twice back-to-back → second cycle `rd_err_o`=1, `v_o`=0, `rd_o` stays 1.
- `data_i`=0x000 → `data_err_o`=1, `v_o`=0, RD unchanged, `lock_o` cleared.
- With `lock_count_p`=3: four valid symbols alternating 0x17C/0x283 → `lock_o`=1 after the 4th. An `rd_load_v_i`=1/`rd_load_i`=1 pulse concurrent with 0x17C leaves `rd_o`=1.

Source files
------------

// File: rtl/bsg_8b10b_pkg.sv
// Shared constants for the 8b/10b symbol decoder: control-code bytes and
// running-disparity encoding.
package bsg_8b10b_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

endpackage

// File: rtl/bsg_8b10b_decode_comb.sv
// Combinational 8b/10b table decode with code-group validity and running
// disparity checks against the supplied RD.
module bsg_8b10b_decode_comb
  import bsg_8b10b_pkg::*;
(
  input  logic [9:0] data_i,
  input  logic       rd_i,
  output logic [7:0] data_o,
  output logic       k_o,
  output logic       rd_o,
  output logic       data_err_o,
  output logic       rd_err_o
);

  logic [5:0] c6;
  logic [3:0] c4, c4k;
  logic [4:0] x;
  logic [2:0] y, n6, n4;
  logic       v6, v4, k28, kx, a7_neg, a7_pos, is_a7;
  logic       mid_neg_ok, mid_pos_ok, mid;

  assign c6  = {data_i[0], data_i[1], data_i[2], data_i[3], data_i[4], data_i[5]};
  assign c4  = {data_i[6], data_i[7], data_i[8], data_i[9]};
  assign n6  = 3'($countones(c6));
  assign n4  = 3'($countones(c4));
  assign k28 = (c6 == 6'b001111) | (c6 == 6'b110000);

  always_comb begin
    x  = '0;
    v6 = 1'b1;
    case (c6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110, 6'b001111, 6'b110000: x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      default:              v6 = 1'b0;
    endcase
  end

  // Which mid-RD values this 6b sub-block can legally leave behind; D7 is
  // neutral but each of its two forms belongs to only one RD.
  assign mid_pos_ok = v6 & ((n6 == 3'd4) | ((n6 == 3'd3) & (c6 != 6'b111000)));
  assign mid_neg_ok = v6 & ((n6 == 3'd2) | ((n6 == 3'd3) & (c6 != 6'b000111)));
  assign a7_neg = ~k28 & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20));
  assign a7_pos = ~k28 & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14));
  assign kx     = ~k28 & ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30));

  always_comb begin
    y     = '0;
    v4    = 1'b0;
    is_a7 = 1'b0;
    c4k   = (c6 == 6'b110000) ? ~c4 : c4;
    if (k28) begin
      v4 = 1'b1;
      case (c4k)
        4'b0100: y = 3'd0;
        4'b1001: y = 3'd1;
        4'b0101: y = 3'd2;
        4'b0011: y = 3'd3;
        4'b0010: y = 3'd4;
        4'b1010: y = 3'd5;
        4'b0110: y = 3'd6;
        4'b1000: y = 3'd7;
        default: v4 = 1'b0;
      endcase
    end else begin
      case (c4)
        4'b1011: begin y = 3'd0; v4 = mid_neg_ok; end
        4'b0100: begin y = 3'd0; v4 = mid_pos_ok; end
        4'b1001: begin y = 3'd1; v4 = 1'b1; end
        4'b0101: begin y = 3'd2; v4 = 1'b1; end
        4'b1100: begin y = 3'd3; v4 = mid_neg_ok; end
        4'b0011: begin y = 3'd3; v4 = mid_pos_ok; end
        4'b1101: begin y = 3'd4; v4 = mid_neg_ok; end
        4'b0010: begin y = 3'd4; v4 = mid_pos_ok; end
        4'b1010: begin y = 3'd5; v4 = 1'b1; end
        4'b0110: begin y = 3'd6; v4 = 1'b1; end
        4'b1110: begin y = 3'd7; v4 = mid_neg_ok & ~a7_neg; end
        4'b0001: begin y = 3'd7; v4 = mid_pos_ok & ~a7_pos; end
        4'b0111: begin y = 3'd7; is_a7 = 1'b1; v4 = mid_neg_ok & (a7_neg | kx); end
        4'b1000: begin y = 3'd7; is_a7 = 1'b1; v4 = mid_pos_ok & (a7_pos | kx); end
        default: v4 = 1'b0;
      endcase
    end
  end

  assign data_o     = {y, x};
  assign k_o        = k28 | (kx & is_a7);
  assign data_err_o = ~v6 | ~v4;

  always_comb begin
    rd_err_o = 1'b0;
    mid      = rd_i;
    if (((n6 == 3'd4) && rd_i == RD_POS) || ((n6 == 3'd2) && rd_i == RD_NEG) ||
        ((c6 == 6'b111000) && rd_i == RD_POS) || ((c6 == 6'b000111) && rd_i == RD_NEG))
      rd_err_o = 1'b1;
    if (n6 == 3'd4)      mid = RD_POS;
    else if (n6 == 3'd2) mid = RD_NEG;
    if (((n4 == 3'd3) && mid == RD_POS) || ((n4 == 3'd1) && mid == RD_NEG) ||
        ((c4 == 4'b1100) && mid == RD_POS) || ((c4 == 4'b0011) && mid == RD_NEG))
      rd_err_o = 1'b1;
    rd_o = mid;
    if (n4 == 3'd3)      rd_o = RD_POS;
    else if (n4 == 3'd1) rd_o = RD_NEG;
  end

endmodule

// File: rtl/bsg_counter_overflow_en.sv
// Enabled up-counter that wraps to zero on the increment past max_val_p and
// flags that increment with a combinational overflow pulse.
module bsg_counter_overflow_en #(
  parameter int max_val_p = 15
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic overflow_o
);

  localparam int width_lp = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1);

  logic [width_lp-1:0] count_r;

  assign overflow_o = en_i & (count_r == width_lp'(max_val_p));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) count_r <= '0;
    else if (en_i)             count_r <= overflow_o ? '0 : count_r + 1'b1;
  end

endmodule

// File: rtl/bsg_dff.sv
// Plain register; reset and enable are folded into the caller's next-value mux.
module bsg_dff #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i) data_o <= data_i;

endmodule

// File: rtl/bsg_8b10b_symbol_decoder.sv
// Registered 8b/10b decoder: one code-group per valid cycle, running
// disparity tracking, error flags and a sticky lock indication.
module bsg_8b10b_symbol_decoder
  import bsg_8b10b_pkg::*;
#(
  parameter int lock_count_p = 15
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       v_i,
  input  logic [9:0] data_i,
  input  logic       rd_load_v_i,
  input  logic       rd_load_i,
  output logic       v_o,
  output logic [7:0] data_o,
  output logic       k_o,
  output logic       data_err_o,
  output logic       rd_err_o,
  output logic       rd_o,
  output logic       lock_o
);

  logic [7:0] dec_data;
  logic       dec_k, dec_rd, dec_data_err, dec_rd_err;
  logic       rd_r, rd_n, sym_ok, sym_bad, lock_ovf;

  bsg_8b10b_decode_comb dec (
    .data_i     (data_i),
    .rd_i       (rd_r),
    .data_o     (dec_data),
    .k_o        (dec_k),
    .rd_o       (dec_rd),
    .data_err_o (dec_data_err),
    .rd_err_o   (dec_rd_err)
  );

  assign sym_ok  = v_i & ~(dec_data_err | dec_rd_err);
  assign sym_bad = v_i &  (dec_data_err | dec_rd_err);

  // A load wins over the decoded RD; the concurrent symbol still used the old RD.
  assign rd_n = !reset_n_i  ? RD_NEG
              : rd_load_v_i ? rd_load_i
              : sym_ok      ? dec_rd
              :               rd_r;

  bsg_dff #(.width_p(1)) rd_reg (
    .clk_i  (clk_i),
    .data_i (rd_n),
    .data_o (rd_r)
  );

  assign rd_o = rd_r;

  bsg_counter_overflow_en #(.max_val_p(lock_count_p)) lock_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (sym_bad),
    .en_i       (sym_ok),
    .overflow_o (lock_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_o        <= 1'b0;
      data_o     <= '0;
      k_o        <= 1'b0;
      data_err_o <= 1'b0;
      rd_err_o   <= 1'b0;
      lock_o     <= 1'b0;
    end else begin
      v_o        <= sym_ok;
      data_err_o <= v_i & dec_data_err;
      rd_err_o   <= v_i & dec_rd_err;
      if (v_i) begin
        data_o <= dec_data;
        k_o    <= dec_k;
      end
      if (sym_bad)       lock_o <= 1'b0;
      else if (lock_ovf) lock_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bsg_8b10b_symbol_decoder.sv
// Bench for the 8b/10b symbol decoder: directed link scenarios then random
// code-groups scored against a table built from an 8b/10b encoder model.
module tb_bsg_8b10b_symbol_decoder;
  import bsg_8b10b_pkg::*;

  localparam int LOCK_N = 3;

  logic       clk = 1'b0;
  logic       reset_n, v, rd_load_v, rd_load;
  logic [9:0] din;
  logic       vo, ko, derr, rderr, rdo, locko;
  logic [7:0] dout;

  always #5 clk = ~clk;

  bsg_8b10b_symbol_decoder #(.lock_count_p(LOCK_N)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .v_i         (v),
    .data_i      (din),
    .rd_load_v_i (rd_load_v),
    .rd_load_i   (rd_load),
    .v_o         (vo),
    .data_o      (dout),
    .k_o         (ko),
    .data_err_o  (derr),
    .rd_err_o    (rderr),
    .rd_o        (rdo),
    .lock_o      (locko)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Encoder tables: RD- column of 5b/6b and 3b/4b, abcdei / fghj MSB-first.
  logic [5:0] e6n [32];
  logic [3:0] e4n [8];
  logic [3:0] k4n [8];
  bit         tv    [1024];
  logic [7:0] tbyte [1024];
  bit         tk    [1024];

  function automatic logic [9:0] pack(logic [5:0] s6, logic [3:0] s4);
    logic [9:0] w;
    for (int b = 0; b < 6; b++) w[b] = s6[5-b];
    for (int b = 0; b < 4; b++) w[6+b] = s4[3-b];
    return w;
  endfunction

  function automatic logic [9:0] enc(int x, int y, bit k, bit r);
    logic [5:0] s6;
    logic [3:0] s4;
    bit mid;
    if (k && x == 28) s6 = r ? 6'b110000 : 6'b001111;
    else begin
      s6 = e6n[x];
      if (r && ($countones(s6) != 3 || x == 7)) s6 = ~s6;
    end
    if ($countones(s6) == 4)      mid = 1'b1;
    else if ($countones(s6) == 2) mid = 1'b0;
    else                          mid = r;
    if (k && x == 28) s4 = mid ? k4n[y] : ~k4n[y];
    else if (y == 7 && (k || (!mid && (x == 17 || x == 18 || x == 20)) ||
                        (mid && (x == 11 || x == 13 || x == 14))))
      s4 = mid ? 4'b1000 : 4'b0111;
    else begin
      s4 = e4n[y];
      if (mid && (y == 0 || y == 3 || y == 4 || y == 7)) s4 = ~s4;
    end
    return pack(s6, s4);
  endfunction

  function automatic logic [9:0] enc_k(int idx, bit r);
    int kx [4] = '{23, 27, 29, 30};
    if (idx < 8) return enc(28, idx, 1'b1, r);
    return enc(kx[idx-8], 7, 1'b1, r);
  endfunction

  function automatic logic [7:0] k_byte(int idx);
    int kx [4] = '{23, 27, 29, 30};
    if (idx < 8) return 8'(idx * 32 + 28);
    return 8'(7 * 32 + kx[idx-8]);
  endfunction

  // Model state
  bit         m_v, m_k, m_de, m_re, m_rd, m_lock, m_known;
  logic [7:0] m_d;
  int         m_cnt;

  task automatic cycle(bit rst_n, bit vi, logic [9:0] d, bit lv, bit lr);
    logic [5:0] s6;
    logic [3:0] s4;
    int  d6, d4;
    bit  mid, re, de, rdn, err;
    reset_n = rst_n; v = vi; din = d; rd_load_v = lv; rd_load = lr;
    @(posedge clk);
    #1;
    for (int b = 0; b < 6; b++) s6[5-b] = d[b];
    for (int b = 0; b < 4; b++) s4[3-b] = d[6+b];
    d6  = 2 * $countones(s6) - 6;
    d4  = 2 * $countones(s4) - 4;
    re  = (d6 == 2 && m_rd) || (d6 == -2 && !m_rd) ||
          (s6 == 6'b111000 && m_rd) || (s6 == 6'b000111 && !m_rd);
    mid = (d6 == 2) ? 1'b1 : (d6 == -2) ? 1'b0 : m_rd;
    re  = re || (d4 == 2 && mid) || (d4 == -2 && !mid) ||
          (s4 == 4'b1100 && mid) || (s4 == 4'b0011 && !mid);
    rdn = (d4 == 2) ? 1'b1 : (d4 == -2) ? 1'b0 : mid;
    de  = !tv[d];
    err = de || re;
    if (!rst_n) begin
      m_v = 0; m_d = '0; m_k = 0; m_de = 0; m_re = 0; m_rd = 0;
      m_lock = 0; m_cnt = 0; m_known = 1;
    end else begin
      if (vi) begin
        m_v = !err; m_de = de; m_re = re;
        if (!err) begin m_d = tbyte[d]; m_k = tk[d]; m_known = 1; end
        else m_known = 0;
        if (err) begin m_cnt = 0; m_lock = 0; end
        else if (m_cnt == LOCK_N) begin m_cnt = 0; m_lock = 1; end
        else m_cnt++;
      end else begin
        m_v = 0; m_de = 0; m_re = 0;
      end
      if (lv) m_rd = lr;
      else if (vi && !err) m_rd = rdn;
    end
    chk("v_o", vo, m_v);
    chk("data_err_o", derr, m_de);
    chk("rd_err_o", rderr, m_re);
    chk("rd_o", rdo, m_rd);
    chk("lock_o", locko, m_lock);
    if (m_known) begin
      chk("data_o", dout, m_d);
      chk("k_o", ko, m_k);
    end
  endtask

  initial begin
    logic [9:0] w;
    int sel;
    e6n = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
            6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
            6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
            6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
            6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
            6'b011110, 6'b101011};
    e4n = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    k4n = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    for (int i = 0; i < 1024; i++) begin tv[i] = 0; tbyte[i] = '0; tk[i] = 0; end
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 8; y++)
        for (int r = 0; r < 2; r++) begin
          w = enc(x, y, 1'b0, r[0]);
          tv[w] = 1; tbyte[w] = 8'(y * 32 + x); tk[w] = 0;
        end
    for (int i = 0; i < 12; i++)
      for (int r = 0; r < 2; r++) begin
        w = enc_k(i, r[0]);
        tv[w] = 1; tbyte[w] = k_byte(i); tk[w] = 1;
      end

    m_rd = 0; m_known = 0; m_cnt = 0; m_lock = 0;

    // Reset must override a concurrent RD load.
    cycle(0, 1, 10'h17C, 1, 1);
    cycle(0, 0, 10'h000, 0, 0);
    chk("rst_rd_o", rdo, 1'b0);
    chk("rst_data_o", dout, 8'h00);

    cycle(1, 1, 10'h17C, 0, 0);
    chk("k285_neg_data", dout, K28_5);
    chk("k285_neg_k", ko, 1'b1);
    chk("k285_neg_rd", rdo, 1'b1);
    cycle(1, 1, 10'h283, 0, 0);
    chk("k285_pos_data", dout, K28_5);
    chk("k285_pos_rd", rdo, 1'b0);
    cycle(1, 1, 10'h0B9, 0, 0);
    chk("d00_data", dout, 8'h00);
    chk("d00_k", ko, 1'b0);
    cycle(1, 1, 10'h17C, 0, 0);
    cycle(1, 1, 10'h17C, 0, 0);
    chk("dbl_k285_rderr", rderr, 1'b1);
    chk("dbl_k285_rd", rdo, 1'b1);
    cycle(1, 0, 10'h000, 0, 0);

    // Lock after LOCK_N+1 clean symbols, then lost on a bad code-group.
    cycle(0, 0, 10'h000, 0, 0);
    cycle(1, 1, 10'h17C, 0, 0);
    cycle(1, 1, 10'h283, 0, 0);
    cycle(1, 1, 10'h17C, 0, 0);
    chk("lock_pre", locko, 1'b0);
    cycle(1, 1, 10'h283, 0, 0);
    chk("lock_set", locko, 1'b1);
    cycle(1, 0, 10'h000, 0, 0);
    chk("lock_sticky", locko, 1'b1);
    cycle(1, 1, 10'h000, 0, 0);
    chk("zero_derr", derr, 1'b1);
    chk("zero_lock", locko, 1'b0);
    chk("zero_rd", rdo, 1'b0);
    cycle(1, 1, 10'h17C, 1, 1);
    chk("load_concurrent_v", vo, 1'b1);
    chk("load_concurrent_rd", rdo, 1'b1);

    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 10)
        cycle(1, 0, 10'($urandom), $urandom_range(0, 30) == 0, 1'($urandom));
      else if (sel < 65)
        cycle(1, 1, enc($urandom_range(0, 31), $urandom_range(0, 7), 1'b0, m_rd),
              $urandom_range(0, 30) == 0, 1'($urandom));
      else if (sel < 75)
        cycle(1, 1, enc_k($urandom_range(0, 11), m_rd), 0, 0);
      else if (sel < 85)
        cycle(1, 1, enc($urandom_range(0, 31), $urandom_range(0, 7), 1'b0, !m_rd), 0, 0);
      else if (sel < 98)
        cycle(1, 1, 10'($urandom), $urandom_range(0, 20) == 0, 1'($urandom));
      else
        cycle(0, 1'($urandom), 10'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
